// File: rtl/mem_arbiter_32.sv
// Two-port round-robin arbiter in front of a single fixed-latency 32-bit memory.
// One access in flight at a time: IDLE -> BUSY (MEM_LAT cycles) -> RESP (ack pulse) -> IDLE.
module mem_arbiter_32 #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic        winner;

  // Single requester wins outright; on a tie the port not granted last time wins.
  assign winner = (req0 && req1) ? ~last_q : req1;

  // NOTE: state registers use non-blocking assignments and reset asynchronously;
  // last_q resets to 1 so that port 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = winner;
          last_d  = winner;
          cnt_d   = LAT_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_en = 1'b1;
        mem_we = sel_q ? we1 : we0;
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        ack0    = ~sel_q;
        ack1    = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_sel   = sel_q;
  assign mem_addr  = sel_q ? addr1 : addr0;
  assign mem_wdata = sel_q ? wdata1 : wdata0;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_32.sv
// Randomized bench for mem_arbiter_32: two requester agents, a bench-side memory and a
// timestamp-based transaction model; plus a directed single read on a MEM_LAT=1 instance.
module tb_mem_arbiter_32;

  localparam int LAT    = 2;
  localparam int CYCLES = 3000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, mem_sel, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_req0, b_ack0, b_ack1, b_sel, b_en, b_we, b_busy;
  logic [31:0] b_addr0, b_rdata, b_maddr, b_mwdata, b_mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter_32 #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter_32 #(.MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .req1(1'b0), .addr0(b_addr0), .addr1(32'h0),
    .wdata0(32'h0), .wdata1(32'h0), .we0(1'b0), .we1(1'b0),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .mem_sel(b_sel),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_en(b_en), .mem_we(b_we),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [logic [31:0]];
  xfer_t       cur [2];
  bit          outst [2];
  bit          reqv [2];
  xfer_t       dq0 [$];
  xfer_t       dq1 [$];
  int          ack_order [$];

  // Transaction model: an access is described by its owner and the number of edges
  // since its grant edge (ph); BUSY is ph 1..LAT, the ack cycle is ph LAT+1.
  bit          inflight = 0;
  int          owner = 0;
  int          ph = 0;
  int          last_m = 1;
  logic [31:0] exp_rdata = '0;
  int          acks_exp = 0;
  int          acks_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic xfer_t next_xfer(input int p);
    xfer_t x;
    if (p == 0 && dq0.size() > 0) return dq0.pop_front();
    if (p == 1 && dq1.size() > 0) return dq1.pop_front();
    x.addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
    x.wdata = $urandom;
    x.we    = 1'($urandom_range(0, 1));
    return x;
  endfunction

  task automatic drive();
    req0   = reqv[0];
    addr0  = cur[0].addr;
    wdata0 = cur[0].wdata;
    we0    = cur[0].we;
    req1   = reqv[1];
    addr1  = cur[1].addr;
    wdata1 = cur[1].wdata;
    we1    = cur[1].we;
  endtask

  task automatic model_step();
    if (inflight) begin
      ph++;
      if (ph == LAT + 1) acks_exp++;
      if (ph == LAT + 2) inflight = 0;
    end else if (reqv[0] || reqv[1]) begin
      owner     = (reqv[0] && reqv[1]) ? 1 - last_m : (reqv[1] ? 1 : 0);
      last_m    = owner;
      inflight  = 1;
      ph        = 1;
      exp_rdata = mem_read(cur[owner].addr);
    end
  endtask

  task automatic check_outputs();
    if (ack0) begin acks_seen++; ack_order.push_back(0); end
    if (ack1) begin acks_seen++; ack_order.push_back(1); end
    if (!rst_n) check("rst_rdata", rdata, 32'h0);
    if (inflight && ph <= LAT) begin
      check("busy_ctl", {busy, mem_en, mem_we, ack0, ack1}, {1'b1, 1'b1, cur[owner].we, 2'b00});
      check("busy_sel", 32'(mem_sel), 32'(owner));
      check("busy_addr", mem_addr, cur[owner].addr);
      check("busy_wdata", mem_wdata, cur[owner].wdata);
    end else if (inflight) begin
      check("resp_ctl", {busy, mem_en, mem_we, ack0, ack1},
            {1'b1, 2'b00, owner == 0, owner == 1});
      check("resp_sel", 32'(mem_sel), 32'(owner));
      if (!cur[owner].we) check("resp_rdata", rdata, exp_rdata);
    end else begin
      check("idle_ctl", {busy, mem_en, mem_we, ack0, ack1}, 5'b0);
    end
  endtask

  initial begin
    bit did_rst = 0;
    bit seen    = 0;
    int lat     = 0;
    int b_acks  = 0;

    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cur[p]   = '{addr: 32'h0, wdata: 32'h0, we: 1'b0};
      outst[p] = 0;
      reqv[p]  = 0;
    end
    drive();
    mem_rdata   = '0;
    b_req0      = 1'b0;
    b_addr0     = '0;
    b_mem_rdata = '0;
    mem[32'h10] = 32'hDEAD_BEEF;
    dq0.push_back('{addr: 32'h10, wdata: 32'h0, we: 1'b0});
    dq1.push_back('{addr: 32'h20, wdata: 32'h1234_5678, we: 1'b1});

    repeat (2) @(negedge clk);
    #1;
    check("rst_ctl", {busy, mem_en, mem_we, ack0, ack1}, 5'b0);
    check("rst_sel", 32'(mem_sel), 32'h0);
    check("rst_rdata0", rdata, 32'h0);
    check("rst_ctl_lat1", {b_busy, b_en, b_we, b_ack0, b_ack1}, 5'b0);

    // Both ports raise their directed requests together as reset is released.
    for (int p = 0; p < 2; p++) begin
      cur[p]   = next_xfer(p);
      outst[p] = 1;
      reqv[p]  = 1;
    end
    rst_n = 1'b1;
    drive();
    #1 mem_rdata = mem_read(mem_addr);

    for (int i = 0; i < CYCLES; i++) begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      if (inflight && ph == LAT && cur[owner].we) mem[cur[owner].addr] = cur[owner].wdata;
      for (int p = 0; p < 2; p++) begin
        if (inflight && owner == p && ph == LAT + 1) begin
          outst[p] = 0;
          reqv[p]  = 0;
        end else if (inflight && owner == p && ph <= LAT && reqv[p] && $urandom_range(0, 9) == 0) begin
          reqv[p] = 0;
        end
        if (!outst[p] && ((p == 0 ? dq0.size() : dq1.size()) > 0 || $urandom_range(0, 3) == 0)) begin
          cur[p]   = next_xfer(p);
          outst[p] = 1;
          reqv[p]  = 1;
        end
      end
      drive();
      #1 mem_rdata = mem_read(mem_addr);

      // One asynchronous reset pulse landing in the second BUSY cycle of an access.
      if (!did_rst && i > 300 && inflight && ph == 2) begin
        did_rst = 1;
        rst_n   = 1'b0;
        #1;
        check("async_rst_ctl", {busy, mem_en, mem_we, ack0, ack1}, 5'b0);
        check("async_rst_sel", 32'(mem_sel), 32'h0);
        check("async_rst_rdata", rdata, 32'h0);
        inflight = 0;
        last_m   = 1;
        for (int p = 0; p < 2; p++) if (outst[p] && !reqv[p]) outst[p] = 0;
      end
    end

    // Let any access still in flight finish with no new requests.
    reqv[0] = 0;
    reqv[1] = 0;
    drive();
    for (int i = 0; i < 2 * LAT + 6; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      #1 mem_rdata = mem_read(mem_addr);
    end

    check("ack_count", 32'(acks_seen), 32'(acks_exp));
    check("first_ack_port", ack_order.size() > 0 ? 32'(ack_order[0]) : 32'hF, 32'h0);
    check("second_ack_port", ack_order.size() > 1 ? 32'(ack_order[1]) : 32'hF, 32'h1);
    check("reset_pulse_hit", 32'(did_rst), 32'h1);

    // MEM_LAT=1 instance: single read, BUSY for one cycle, ack two edges after grant.
    @(negedge clk);
    b_req0      = 1'b1;
    b_addr0     = 32'h40;
    b_mem_rdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("lat1_busy", {b_busy, b_en, b_we, b_ack0}, 4'b1100);
        check("lat1_addr", b_maddr, 32'h40);
      end
      if (b_ack0 || b_ack1) b_acks++;
      if (b_ack0 && !seen) begin
        seen = 1;
        lat  = k;
        check("lat1_rdata", b_rdata, 32'hCAFE_F00D);
        b_req0 = 1'b0;
      end
    end
    check("lat1_ack_edge", 32'(lat), 32'h2);
    check("lat1_ack_pulses", 32'(b_acks), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_32.md
MEM_ARBITER_32 -- requirements
Module: mem_arbiter_32

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning memory access latency in cycles; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0/req1  input  1  access request from port 0/1; level, held until ack.
REQ-005 SHALL have ports addr0/addr1  input  32  request address; stable while req high.
REQ-006 SHALL have ports wdata0/wdata1  input  32  write data; stable while req high.
REQ-007 SHALL have ports we0/we1  input  1  write enable; 1 = write, 0 = read.
REQ-008 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse to port 0/1.
REQ-009 SHALL have port rdata  output  32  registered read data; valid only while ack0 or ack1 is high.
REQ-010 SHALL have port mem_sel  output  1  select to the shared 32-bit 2:1 mux pair (0 = port 0, 1 = port 1).
REQ-011 SHALL have ports mem_addr/mem_wdata  output  32  mux outputs of addr and wdata, selected by mem_sel.
REQ-012 SHALL have ports mem_en/mem_we  output  1  memory enable / write strobe.
REQ-013 SHALL have port mem_rdata  input  32  memory read data, valid in last BUSY cycle.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 IDLE: if req0 or req1 high, SHALL latch winner into mem_sel, load counter with MEM_LAT-1, go BUSY; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single requester wins; both requesting -> port not granted last wins; last_grant updates at each grant.
REQ-018 BUSY: mem_en SHALL be 1, mem_we SHALL equal we of selected port; counter decrements each cycle.
REQ-019 BUSY with counter == 0: SHALL capture mem_rdata into rdata register and go RESP; BUSY therefore lasts exactly MEM_LAT cycles.
REQ-020 RESP: SHALL assert ack of granted port for exactly one cycle, mem_en = mem_we = 0, then go IDLE.
REQ-021 Latency: request first sampled in IDLE at edge t -> ack high in cycle t+MEM_LAT+1; next grant earliest at edge t+MEM_LAT+2.
REQ-022 mem_sel SHALL remain constant from grant through RESP; mem_addr/mem_wdata SHALL be pure mux of inputs by mem_sel.
REQ-023 Non-granted port's req SHALL stay pending with no side effect; served at next IDLE arbitration.
REQ-024 rdata on write completion SHALL be don't-care; bench does not check it.
REQ-025 Requester dropping req mid-access SHALL not abort the access; ack still issued.
REQ-026 ack0 and ack1 SHALL never be high simultaneously; at most one access in flight.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counter 0, mem_sel 0, last_grant 1 (port 0 wins first tie), rdata 0.
REQ-028 During and after reset: ack0 = ack1 = mem_en = mem_we = busy = 0.
REQ-029 Reset mid-BUSY or mid-RESP SHALL abandon the access with no ack; after release, pending reqs re-arbitrated from IDLE.

Verification
REQ-030 MEM_LAT=2, req0 read addr0=0x10, mem_rdata=0xDEADBEEF -> mem_en high 2 cycles, ack0 in cycle t+3 with rdata=0xDEADBEEF, mem_sel=0.
REQ-031 req0 and req1 high together right after reset -> port 0 served first, then port 1; mem_sel 0 then 1; acks 4 cycles apart (MEM_LAT=2).
REQ-032 Both ports hold req continuously over 4 accesses -> grants alternate 0,1,0,1; no ack overlap.
REQ-033 req1 write addr1=0x20, wdata1=0x12345678 -> mem_we high exactly MEM_LAT cycles with mem_addr=0x20, mem_wdata=0x12345678; ack1 one pulse.
REQ-034 rst_n pulsed low in 2nd BUSY cycle -> all outputs 0 asynchronously, no ack; after release held req re-granted and completes normally.
REQ-035 MEM_LAT=1 single read -> BUSY one cycle, ack in cycle t+2.
